// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field-level descriptors into machine words and
// writes them to consecutive instruction-memory locations, one word per two
// cycles, with sticky done/error status per load session.
module instr_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            kind_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [31:0]           imm_i,
  input  logic                  last_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The write that brings count_o up to DEPTH happens while count_o holds DEPTH-1.
  localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_PTR   = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_WIDTH-1:0] ptr;
  logic                  last_q;
  logic                  ready_d;
  logic                  we_d;
  logic                  accept;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic [2:0]  arith_f3;
  logic        fits_i;
  logic        fits_b;
  logic        fits_j;
  logic        fits_u;

  assign accept = (state == ACCEPT) && valid_i;

  // Immediate range checks: the value must survive truncation to the format's width.
  always_comb begin
    fits_i = (imm_i[31:11] == {21{imm_i[11]}});
    fits_b = (imm_i[31:12] == {20{imm_i[12]}}) && !imm_i[0];
    fits_j = (imm_i[31:20] == {12{imm_i[20]}}) && !imm_i[0];
    fits_u = (imm_i[11:0] == 12'd0);
  end

  // Combinational packer: builds the machine word and flags descriptors the decoder cannot accept.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b0;
    arith_f3  = 3'b000;
    case (kind_i)
      5'd2, 5'd6: arith_f3 = 3'b010;
      5'd3, 5'd7: arith_f3 = 3'b110;
      5'd4, 5'd8: arith_f3 = 3'b111;
      default:    arith_f3 = 3'b000;
    endcase
    case (kind_i)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: begin
        enc_word  = {1'b0, (kind_i == 5'd1), 5'b00000, rs2_i, rs1_i, arith_f3, rd_i, OP_R};
        enc_legal = 1'b1;
      end
      5'd5, 5'd6, 5'd7, 5'd8: begin
        enc_word  = {imm_i[11:0], rs1_i, arith_f3, rd_i, OP_I_ARITH};
        enc_legal = fits_i;
      end
      5'd9: begin
        enc_word  = {imm_i[11:0], rs1_i, 3'b010, rd_i, OP_LOAD};
        enc_legal = fits_i;
      end
      5'd10: begin
        enc_word  = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OP_STORE};
        enc_legal = fits_i;
      end
      5'd11, 5'd12: begin
        enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 2'b00, (kind_i == 5'd12),
                     imm_i[4:1], imm_i[11], OP_BRANCH};
        enc_legal = fits_b;
      end
      5'd13: begin
        enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        enc_legal = fits_j;
      end
      5'd14: begin
        enc_word  = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
        enc_legal = fits_i;
      end
      5'd15: begin
        enc_word  = {imm_i[31:12], rd_i, OP_LUI};
        enc_legal = fits_u;
      end
      5'd16: begin
        enc_word  = {imm_i[31:12], rd_i, OP_AUIPC};
        enc_legal = fits_u;
      end
      default: begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic: start only matters between sessions, overflow only when the word was not the last.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: if (start_i) next_state = ACCEPT;
      ACCEPT: if (valid_i) next_state = enc_legal ? WRITE : ERROR;
      WRITE: begin
        if (last_q)                     next_state = DONE;
        else if (count_o == LAST_COUNT) next_state = ERROR;
        else                            next_state = ACCEPT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so ready_o and mem_we_o come straight from flops.
  always_comb begin
    ready_d = (next_state == ACCEPT);
    we_d    = (next_state == WRITE);
  end

  // Datapath: write pointer, registered memory port, session counters and sticky status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_o     <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
      count_o     <= '0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      ptr         <= BASE_PTR;
      last_q      <= 1'b0;
    end else begin
      ready_o  <= ready_d;
      mem_we_o <= we_d;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            ptr     <= BASE_PTR;
            count_o <= '0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
          end
        end
        ACCEPT: begin
          if (accept) begin
            if (enc_legal) begin
              mem_addr_o  <= ptr;
              mem_wdata_o <= enc_word;
              last_q      <= last_i;
            end else begin
              error_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          ptr     <= ptr + 1'b1;
          count_o <= count_o + 1'b1;
          if (last_q)                     done_o  <= 1'b1;
          else if (count_o == LAST_COUNT) error_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-encoded expected words for
// instr_encoder (DEPTH=4 so the overflow path is reachable).
module tb_instr_encoder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [4:0]    kind = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [31:0]   imm = '0;
  logic          last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          error;

  int tests_run  = 0;
  int fail_count = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        prev_we   = 1'b0;
  logic        consec_we = 1'b0;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .valid_i(valid),
    .ready_o(ready),
    .kind_i(kind),
    .rd_i(rd),
    .rs1_i(rs1),
    .rs2_i(rs2),
    .imm_i(imm),
    .last_i(last),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .count_o(count),
    .done_o(done),
    .error_o(error)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Write monitor: logs every memory write and flags back-to-back strobes.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(32'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (prev_we && mem_we) consec_we = 1'b1;
    prev_we = mem_we;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one descriptor and holds it until accepted or the cycle budget runs out;
  // returns at the negedge following the accepting edge.
  task automatic apply_stimulus(input logic [4:0] k, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [31:0] im, input logic lst,
                                output logic ok);
    int n = 0;
    kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
    valid = 1'b1;
    while (!ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = ready;
    if (ok) begin
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
    end else begin
      valid = 1'b0;
    end
  endtask

  initial begin
    logic ok;
    int   base;

    // Reset values
    @(negedge clk);
    check_output("rst_ready", 32'(ready), 32'd0);
    check_output("rst_we", 32'(mem_we), 32'd0);
    check_output("rst_addr", 32'(mem_addr), 32'd0);
    check_output("rst_wdata", mem_wdata, 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    valid = 1'b1;
    wait_cycles(2);
    check_output("idle_no_ready", 32'(ready), 32'd0);
    valid = 1'b0;

    // Single ADDI
    start_session();
    check_output("start_ready", 32'(ready), 32'd1);
    apply_stimulus(5'd5, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, ok);
    check_output("addi_accepted", 32'(ok), 32'd1);
    wait_cycles(2);
    check_output("addi_nwrites", 32'(wr_addr_q.size()), 32'd1);
    check_output("addi_addr", wr_addr_q[0], 32'd0);
    check_output("addi_word", wr_data_q[0], 32'h00500093);
    check_output("addi_count", 32'(count), 32'd1);
    check_output("addi_done", 32'(done), 32'd1);
    check_output("addi_ready_after_done", 32'(ready), 32'd0);

    // ADD then SUB
    wr_addr_q.delete(); wr_data_q.delete();
    start_session();
    apply_stimulus(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, ok);
    apply_stimulus(5'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, ok);
    wait_cycles(2);
    check_output("addsub_nwrites", 32'(wr_addr_q.size()), 32'd2);
    check_output("add_word", wr_data_q[0], 32'h002081B3);
    check_output("sub_word", wr_data_q[1], 32'h402081B3);
    check_output("sub_addr", wr_addr_q[1], 32'd1);
    check_output("addsub_count", 32'(count), 32'd2);
    check_output("no_consecutive_we", 32'(consec_we), 32'd0);

    // Memory/branch/jump formats, last on the DEPTH-th word
    wr_addr_q.delete(); wr_data_q.delete();
    start_session();
    apply_stimulus(5'd9, 5'd5, 5'd1, 5'd0, 32'd4, 1'b0, ok);
    apply_stimulus(5'd10, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, ok);
    apply_stimulus(5'd11, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, ok);
    apply_stimulus(5'd13, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, ok);
    wait_cycles(2);
    check_output("fmt_nwrites", 32'(wr_addr_q.size()), 32'd4);
    check_output("lw_word", wr_data_q[0], 32'h0040A283);
    check_output("sw_word", wr_data_q[1], 32'h0020A423);
    check_output("beq_word", wr_data_q[2], 32'hFE208EE3);
    check_output("jal_word", wr_data_q[3], 32'h008000EF);
    check_output("jal_addr", wr_addr_q[3], 32'd3);
    check_output("fmt_done", 32'(done), 32'd1);
    check_output("fmt_error", 32'(error), 32'd0);

    wr_addr_q.delete(); wr_data_q.delete();
    start_session();
    apply_stimulus(5'd15, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, ok);
    wait_cycles(2);
    check_output("lui_word", wr_data_q[0], 32'h123452B7);
    check_output("lui_addr", wr_addr_q[0], 32'd0);

    // Odd branch offset aborts the session after one legal word
    wr_addr_q.delete(); wr_data_q.delete();
    start_session();
    apply_stimulus(5'd5, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, ok);
    apply_stimulus(5'd11, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, ok);
    wait_cycles(2);
    check_output("badbeq_nwrites", 32'(wr_addr_q.size()), 32'd1);
    check_output("badbeq_error", 32'(error), 32'd1);
    check_output("badbeq_count", 32'(count), 32'd1);
    check_output("badbeq_ready", 32'(ready), 32'd0);
    start_session();
    check_output("restart_error_clr", 32'(error), 32'd0);
    check_output("restart_count_clr", 32'(count), 32'd0);
    apply_stimulus(5'd5, 5'd2, 5'd0, 5'd0, -32'sd2048, 1'b1, ok);
    wait_cycles(2);
    check_output("restart_addr", wr_addr_q[1], 32'd0);
    check_output("addi_min_imm_word", wr_data_q[1], 32'h80000113);

    // I-type immediate one past the top of the range
    base = wr_addr_q.size();
    start_session();
    apply_stimulus(5'd5, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, ok);
    wait_cycles(2);
    check_output("addi2048_nowrite", 32'(wr_addr_q.size()), 32'(base));
    check_output("addi2048_error", 32'(error), 32'd1);

    // Illegal kind
    start_session();
    apply_stimulus(5'd17, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, ok);
    wait_cycles(2);
    check_output("kind17_error", 32'(error), 32'd1);
    check_output("kind17_count", 32'(count), 32'd0);

    // Overflow at DEPTH=4
    wr_addr_q.delete(); wr_data_q.delete();
    start_session();
    for (int i = 0; i < 4; i++) apply_stimulus(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, ok);
    apply_stimulus(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, ok);
    check_output("fifth_not_accepted", 32'(ok), 32'd0);
    check_output("ovf_nwrites", 32'(wr_addr_q.size()), 32'd4);
    check_output("ovf_last_addr", wr_addr_q[3], 32'd3);
    check_output("ovf_error", 32'(error), 32'd1);
    check_output("ovf_count", 32'(count), 32'd4);
    check_output("ovf_ready", 32'(ready), 32'd0);
    check_output("ovf_no_consecutive_we", 32'(consec_we), 32'd0);

    // Reset during the write cycle
    start_session();
    apply_stimulus(5'd5, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, ok);
    check_output("midrst_we_before", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_we", 32'(mem_we), 32'd0);
    check_output("midrst_addr", 32'(mem_addr), 32'd0);
    check_output("midrst_wdata", mem_wdata, 32'd0);
    check_output("midrst_count", 32'(count), 32'd0);
    check_output("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_addr_q.size();
    wait_cycles(3);
    check_output("midrst_idle_ready", 32'(ready), 32'd0);
    check_output("midrst_no_write", 32'(wr_addr_q.size()), 32'(base));
    check_output("midrst_done_after", 32'(done), 32'd0);
    start_session();
    check_output("midrst_resume_ready", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
